// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the rv32 inter-stage pipeline queue.
//   NOP_CODE     : instruction word presented while a stage holds a bubble
//                  (addi x0, x0, 0).
//   pipe_state_t : fill level of the queue. The encoding equals the number
//                  of entries held.
package rv32_pipe_pkg;

   localparam logic [31:0] NOP_CODE = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

endpackage : rv32_pipe_pkg

// File: rtl/rv32_pipe_slot.sv
// One storage slot of the pipeline queue: a valid bit plus a registered
// {data, ctrl, code} record.
//   clk, rst            : clock and asynchronous active-high reset
//   load_i              : capture data_i/ctrl_i/code_i and mark the slot valid
//   clear_i             : invalidate the slot; has priority over load_i and
//                         leaves the payload untouched
//   data_i/ctrl_i/code_i: record to capture
//   valid_o             : slot holds a live entry
//   data_o/ctrl_o/code_o: stored record
module rv32_pipe_slot
   import rv32_pipe_pkg::*;
#(
   parameter int unsigned        DATA_W   = 128,
   parameter int unsigned        CTRL_W   = 4,
   parameter logic [CTRL_W-1:0]  CTRL_RST = CTRL_W'(4'b1000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [31:0]       code_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [31:0]       code_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [31:0]       code_q;

   // NOTE: the payload is reset as well as the valid bit, so the outputs show
   // a defined bubble record straight out of reset instead of X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of block evaluation order.
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= CTRL_RST;
         code_q  <= NOP_CODE;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         ctrl_q  <= ctrl_i;
         code_q  <= code_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;
   assign code_o  = code_q;

endmodule : rv32_pipe_slot

// File: rtl/rv32_pipe_skid_queue.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
// Empty slots present a NOP bubble downstream.
//   clk, rst                    : clock, asynchronous active-high reset
//   flush_i                     : squash all held entries at the next edge
//   in_valid_i / in_ready_o     : upstream handshake
//   in_data_i/in_ctrl_i/in_code_i : upstream payload, control, instruction
//   out_valid_o / out_ready_i   : downstream handshake
//   out_data_o/out_ctrl_o/out_code_o : head entry (bubble when !out_valid_o)
//   occupancy_o                 : entries held (0..2)
//   stall_cnt_o                 : cycles with out_valid_o & !out_ready_i
// SKID=1 registers in_ready_o (no path from out_ready_i); SKID=0 keeps a
// single entry and derives in_ready_o combinationally.
module rv32_pipe_skid_queue
   import rv32_pipe_pkg::*;
#(
   parameter int unsigned        DATA_W   = 128,
   parameter int unsigned        CTRL_W   = 4,
   parameter bit                 SKID     = 1'b1,
   parameter logic [CTRL_W-1:0]  CTRL_RST = CTRL_W'(4'b1000),
   parameter int unsigned        CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [31:0]       in_code_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [31:0]       out_code_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pipe_state_t state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic in_fire, out_fire;
   logic main_load, main_clear, main_from_skid;
   logic skid_load, skid_clear;

   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data,  skid_data,  main_data_in;
   logic [CTRL_W-1:0] main_ctrl,  skid_ctrl,  main_ctrl_in;
   logic [31:0]       main_code,  skid_code,  main_code_in;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = main_valid & out_ready_i;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush_i) begin
         // Flush beats everything; a same-cycle out_fire was still delivered.
         state_d    = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_load = 1'b1;
                  state_d   = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  // Only reachable with SKID=1: with SKID=0 in_fire in ONE
                  // implies out_ready_i, hence out_fire.
                  skid_load = 1'b1;
                  state_d   = TWO;
               end else if (out_fire) begin
                  main_clear = 1'b1;
                  state_d    = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   // ------------------------------------------------------ stall counter
   // Counts backpressured cycles; saturates and is deliberately not cleared
   // by flush so performance counts survive pipeline squashes.
   always_comb begin
      stall_d = stall_q;
      if (main_valid && !out_ready_i && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // --------------------------------------------------------------- slots
   assign main_data_in = main_from_skid ? skid_data : in_data_i;
   assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;
   assign main_code_in = main_from_skid ? skid_code : in_code_i;

   rv32_pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clear_i (main_clear),
      .data_i  (main_data_in),
      .ctrl_i  (main_ctrl_in),
      .code_i  (main_code_in),
      .valid_o (main_valid),
      .data_o  (main_data),
      .ctrl_o  (main_ctrl),
      .code_o  (main_code)
   );

   if (SKID) begin : g_skid
      rv32_pipe_slot #(
         .DATA_W   (DATA_W),
         .CTRL_W   (CTRL_W),
         .CTRL_RST (CTRL_RST)
      ) u_skid (
         .clk     (clk),
         .rst     (rst),
         .load_i  (skid_load),
         .clear_i (skid_clear),
         .data_i  (in_data_i),
         .ctrl_i  (in_ctrl_i),
         .code_i  (in_code_i),
         .valid_o (skid_valid),
         .data_o  (skid_data),
         .ctrl_o  (skid_ctrl),
         .code_o  (skid_code)
      );

      // Ready for the coming cycle is "not full after this edge"; being a
      // flop, it breaks the out_ready -> in_ready combinational chain.
      logic in_ready_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            in_ready_q <= 1'b1;
         end else begin
            in_ready_q <= (state_d != TWO);
         end
      end
      assign in_ready_o = in_ready_q;
   end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = CTRL_RST;
      assign skid_code  = NOP_CODE;
      assign in_ready_o = !main_valid | out_ready_i;
   end

   // ------------------------------------------------------------- outputs
   assign out_valid_o = main_valid;
   assign out_data_o  = main_data;
   assign out_ctrl_o  = main_valid ? main_ctrl : CTRL_RST;
   assign out_code_o  = main_valid ? main_code : NOP_CODE;
   assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
   assign stall_cnt_o = stall_q;

endmodule : rv32_pipe_skid_queue

// File: tb/tb_rv32_pipe_skid_queue.sv
// Self-checking bench for rv32_pipe_skid_queue. Three instances share one
// stimulus: SKID=1/CNT_W=16, SKID=0/CNT_W=16 and SKID=1/CNT_W=4. "sel"
// chooses which one the checks and the scoreboard observe.
module tb_rv32_pipe_skid_queue;
   import rv32_pipe_pkg::*;

   localparam int          DW   = 32;
   localparam int          CW   = 4;
   localparam logic [CW-1:0] CRST = 4'b1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic [31:0]   in_code;

   logic          a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
   logic [DW-1:0] a_data, b_data, c_data;
   logic [CW-1:0] a_ctrl, b_ctrl, c_ctrl;
   logic [31:0]   a_code, b_code, c_code;
   logic [1:0]    a_occ, b_occ, c_occ;
   logic [15:0]   a_stall, b_stall;
   logic [3:0]    c_stall;

   rv32_pipe_skid_queue #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CTRL_RST(CRST), .CNT_W(16)) u_skid (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_ir),
      .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_code_i(in_code),
      .out_valid_o(a_ov), .out_ready_i(out_ready), .out_data_o(a_data), .out_ctrl_o(a_ctrl),
      .out_code_o(a_code), .occupancy_o(a_occ), .stall_cnt_o(a_stall));

   rv32_pipe_skid_queue #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CTRL_RST(CRST), .CNT_W(16)) u_noskid (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_ir),
      .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_code_i(in_code),
      .out_valid_o(b_ov), .out_ready_i(out_ready), .out_data_o(b_data), .out_ctrl_o(b_ctrl),
      .out_code_o(b_code), .occupancy_o(b_occ), .stall_cnt_o(b_stall));

   rv32_pipe_skid_queue #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CTRL_RST(CRST), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(c_ir),
      .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_code_i(in_code),
      .out_valid_o(c_ov), .out_ready_i(out_ready), .out_data_o(c_data), .out_ctrl_o(c_ctrl),
      .out_code_o(c_code), .occupancy_o(c_occ), .stall_cnt_o(c_stall));

   // ------------------------------------------------ observed instance mux
   int            sel;
   logic          cur_ir, cur_ov;
   logic [DW-1:0] cur_data;
   logic [CW-1:0] cur_ctrl;
   logic [31:0]   cur_code;
   logic [1:0]    cur_occ;
   logic [15:0]   cur_stall;

   always_comb begin
      cur_ir = a_ir; cur_ov = a_ov; cur_data = a_data; cur_ctrl = a_ctrl;
      cur_code = a_code; cur_occ = a_occ; cur_stall = a_stall;
      case (sel)
         1: begin
            cur_ir = b_ir; cur_ov = b_ov; cur_data = b_data; cur_ctrl = b_ctrl;
            cur_code = b_code; cur_occ = b_occ; cur_stall = b_stall;
         end
         2: begin
            cur_ir = c_ir; cur_ov = c_ov; cur_data = c_data; cur_ctrl = c_ctrl;
            cur_code = c_code; cur_occ = c_occ; cur_stall = {12'h000, c_stall};
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ checking
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------- scoreboard
   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      logic [31:0]   code;
   } entry_t;

   entry_t sb_q[$];
   bit     sb_en = 1'b0;

   always @(negedge clk) begin
      if (sb_en && !rst) begin
         if (cur_ov && out_ready) begin
            check("out_pending", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
               entry_t exp_e;
               exp_e = sb_q.pop_front();
               check("out_entry", {cur_data, cur_ctrl, cur_code}, exp_e);
            end
         end
         if (!cur_ov) begin
            check("bubble_ctrl", cur_ctrl, CRST);
            check("bubble_code", cur_code, 32'h0000_0013);
         end
         if (flush) sb_q.delete();
         else if (in_valid && cur_ir) sb_q.push_back('{in_data, in_ctrl, in_code});
      end
   end

   // ------------------------------------------------------------- driving
   int tag = 0;
   bit fired;

   task automatic set_data();
      in_data = 32'hA000_0000 + tag;
      in_ctrl = tag[3:0];
      in_code = (tag << 12) | 32'h33;
   endtask

   task automatic set_in(input bit iv, input bit ordy, input bit fl);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Called at the negedge: records the handshake, moves past the next edge.
   task automatic next_cycle();
      fired = in_valid & cur_ir;
      @(posedge clk); #1;
      if (fired) begin
         tag++;
         set_data();
      end
   endtask

   task automatic do_reset();
      sb_en = 1'b0;
      set_in(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb_q.delete();
      sb_en = 1'b1;
   endtask

   // ----------------------------------------------------------- vectors
   typedef struct {
      bit         iv, ordy, fl;
      bit         e_ir, e_ov;
      logic [1:0] e_occ;
      int         e_stall;
   } vec_t;

   vec_t vec [22];

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         set_in(vec[i].iv, vec[i].ordy, vec[i].fl);
         @(negedge clk);
         check($sformatf("row%0d_in_ready", i), cur_ir, vec[i].e_ir);
         check($sformatf("row%0d_out_valid", i), cur_ov, vec[i].e_ov);
         check($sformatf("row%0d_occupancy", i), cur_occ, vec[i].e_occ);
         check($sformatf("row%0d_stall_cnt", i), cur_stall, 16'(vec[i].e_stall));
         next_cycle();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //        iv ordy fl   ir ov occ stall
      // SKID=1: stall with A,B held and C waiting, then release
      vec[0]  = '{1, 0, 0,  1, 0, 2'd0, 0};
      vec[1]  = '{1, 0, 0,  1, 1, 2'd1, 0};
      vec[2]  = '{1, 0, 0,  0, 1, 2'd2, 1};
      vec[3]  = '{1, 0, 0,  0, 1, 2'd2, 2};
      vec[4]  = '{1, 1, 0,  0, 1, 2'd2, 3};
      vec[5]  = '{1, 1, 0,  1, 1, 2'd1, 3};
      vec[6]  = '{0, 1, 0,  1, 1, 2'd1, 3};
      vec[7]  = '{0, 0, 0,  1, 0, 2'd0, 3};
      // SKID=1: flush in TWO with in_valid, then flush in ONE with in_fire
      vec[8]  = '{1, 0, 0,  1, 0, 2'd0, 3};
      vec[9]  = '{1, 0, 0,  1, 1, 2'd1, 3};
      vec[10] = '{1, 0, 1,  0, 1, 2'd2, 4};
      vec[11] = '{0, 0, 0,  1, 0, 2'd0, 5};
      vec[12] = '{1, 0, 0,  1, 0, 2'd0, 5};
      vec[13] = '{1, 0, 1,  1, 1, 2'd1, 5};
      vec[14] = '{0, 1, 0,  1, 0, 2'd0, 6};
      // SKID=0: full blocks input, out_ready pulse replaces with no gap
      vec[15] = '{1, 0, 0,  1, 0, 2'd0, 0};
      vec[16] = '{1, 0, 0,  0, 1, 2'd1, 0};
      vec[17] = '{1, 0, 0,  0, 1, 2'd1, 1};
      vec[18] = '{1, 1, 0,  1, 1, 2'd1, 2};
      vec[19] = '{0, 0, 0,  0, 1, 2'd1, 2};
      vec[20] = '{0, 1, 0,  1, 1, 2'd1, 3};
      vec[21] = '{0, 0, 0,  1, 0, 2'd0, 3};

      sel = 0;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0);
      set_data();
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_in_ready", cur_ir, 1'b1);
      check("rst_out_valid", cur_ov, 1'b0);
      check("rst_occupancy", cur_occ, 2'd0);
      check("rst_stall_cnt", cur_stall, 16'd0);
      check("rst_out_data", cur_data, 32'd0);
      check("rst_out_ctrl", cur_ctrl, CRST);
      check("rst_out_code", cur_code, 32'h0000_0013);
      @(posedge clk); #1;

      // Reset asserted mid-stream with two entries held
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b0, 1'b0);
         @(negedge clk);
         next_cycle();
      end
      @(negedge clk);
      check("pre_rst_occupancy", cur_occ, 2'd2);
      check("pre_rst_stall_cnt", cur_stall, 16'd1);
      sb_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_rst_out_valid", cur_ov, 1'b0);
      check("async_rst_out_code", cur_code, 32'h0000_0013);
      check("async_rst_out_ctrl", cur_ctrl, CRST);
      check("async_rst_occupancy", cur_occ, 2'd0);
      check("async_rst_stall_cnt", cur_stall, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;  // released while in_valid is still high
      sb_q.delete();
      sb_en = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", cur_ir, 1'b1);
      check("post_rst_out_valid", cur_ov, 1'b0);
      next_cycle();
      do_reset();

      // Stream 8 entries with out_ready held high
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 1'b1, 1'b0);
         @(negedge clk);
         check($sformatf("stream%0d_in_ready", i), cur_ir, 1'b1);
         check($sformatf("stream%0d_out_valid", i), cur_ov, (i > 0));
         next_cycle();
      end
      set_in(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("stream_last_out_valid", cur_ov, 1'b1);
      next_cycle();
      @(negedge clk);
      check("stream_drained", cur_ov, 1'b0);
      check("stream_stall_cnt", cur_stall, 16'd0);
      check("stream_sb_empty", sb_q.size(), 0);
      next_cycle();

      // Stall/skid and flush sequences (SKID=1)
      do_reset();
      run_rows(0, 14);
      check("skid_sb_empty", sb_q.size(), 0);

      // Single-entry variant
      sel = 1;
      do_reset();
      run_rows(15, 21);
      check("single_sb_empty", sb_q.size(), 0);

      // Stall counter saturation with CNT_W=4
      sel = 2;
      do_reset();
      set_in(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      next_cycle();
      for (int k = 0; k < 20; k++) begin
         set_in(1'b0, 1'b0, 1'b0);
         @(negedge clk);
         check($sformatf("sat%0d_stall_cnt", k), cur_stall, 16'((k < 15) ? k : 15));
         next_cycle();
      end
      set_in(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("sat_final_stall_cnt", cur_stall, 16'd15);
      next_cycle();
      @(negedge clk);
      check("sat_sb_empty", sb_q.size(), 0);
      check("sat_drained", cur_ov, 1'b0);
      sb_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rv32_pipe_skid_queue
